uart_rx: RTL and testbench

- Serial receiver that consumes the line produced by uart_tx: 8N1 framing, LSB first, idle-high line.
- Synchronises the asynchronous rx_in and detects the start bit with a mid-bit re-check.
- Samples each data bit and the stop bit once per bit period, then presents the byte with a one-cycle valid strobe.
- Sits between the pad and the downstream byte consumer, in the same clock domain and with the same baud divisor as uart_tx.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and framing constants.
// Imported by uart_rx and uart_tx so both ends agree on frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 521;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input; resets to 1 so an idle-high
// line does not look like activity while reset is being released.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, re-checks the start bit at mid-bit, samples
// each data bit and the stop bit once per bit period, and strobes good or bad frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 busy_q;

  uart_sync2 u_sync (
    .clk_i   (rx_clk),
    .rst_i   (rx_rst),
    .async_i (rx_in),
    .sync_o  (rx_s)
  );

  assign cnt_d = cnt_q + CNT_W'(1);
  assign idx_d = idx_q + IDX_W'(1);

  // busy_q is updated on every transition so it always mirrors (state_q != IDLE).
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q < CNT_HALF) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
              state_q <= STOP;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        STOP: begin
          if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK_WAIT;
            end
          end
        end
        // A held-low line must return high before another start bit can be recognised.
        BREAK_WAIT: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver queues the expected byte/error and its
// strobe cycle, and per-DUT monitors pop and compare whenever a strobe appears.
module tb_uart_rx;

  localparam int C0 = 16;
  localparam int C1 = 521;

  typedef struct {
    bit          isErr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       rxLine [2];
  logic [7:0] data0, data1;
  logic       valid0, valid1, ferr0, ferr1, busy0, busy1;

  int         cyc = 0;
  int         assertCount = 0;
  int         failCount = 0;
  exp_t       expQ0 [$];
  exp_t       expQ1 [$];
  exp_t       got0, got1;
  logic [7:0] lastGood [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx #(.CLKS_PER_BIT(C0)) dut16 (
    .rx_clk(clk), .rx_rst(rst0), .rx_in(rxLine[0]),
    .rx_data(data0), .rx_valid(valid0), .rx_frame_err(ferr0), .rx_busy(busy0)
  );

  uart_rx dut521 (
    .rx_clk(clk), .rx_rst(rst1), .rx_in(rxLine[1]),
    .rx_data(data1), .rx_valid(valid1), .rx_frame_err(ferr1), .rx_busy(busy1)
  );

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a frame is good iff its stop bit is 1; the strobe appears one cycle
  // after the stop-bit sample at k+3+H+9C, where k is the first edge seeing the line low.
  task automatic applyStimulus(input int idx, input logic [7:0] b, input bit stopBit);
    int   c;
    int   k;
    exp_t e;
    c = (idx == 0) ? C0 : C1;
    rxLine[idx] = 1'b0;
    k = cyc + 1;
    e.isErr = !stopBit;
    e.data  = stopBit ? b : lastGood[idx];
    e.cyc   = k + 3 + (c - 1) / 2 + 9 * c;
    if (stopBit) lastGood[idx] = b;
    if (idx == 0) expQ0.push_back(e);
    else          expQ1.push_back(e);
    waitCycles(c);
    for (int i = 0; i < 8; i++) begin
      rxLine[idx] = b[i];
      waitCycles(c);
    end
    rxLine[idx] = stopBit;
    waitCycles(c);
  endtask

  task automatic compareEvent(input int idx, input exp_t x, input logic v,
                              input logic fe, input logic [7:0] d);
    checkOutput("strobe_exclusive", idx, {31'd0, v & fe}, 32'd0);
    checkOutput("rx_valid", idx, {31'd0, v}, {31'd0, !x.isErr});
    checkOutput("rx_frame_err", idx, {31'd0, fe}, {31'd0, x.isErr});
    checkOutput("rx_data", idx, {24'd0, d}, {24'd0, x.data});
    checkOutput("strobe_cycle", idx, cyc, x.cyc);
  endtask

  task automatic checkResetState(input int idx);
    if (idx == 0) begin
      checkOutput("reset_data", 0, {24'd0, data0}, 32'd0);
      checkOutput("reset_valid", 0, {31'd0, valid0}, 32'd0);
      checkOutput("reset_ferr", 0, {31'd0, ferr0}, 32'd0);
      checkOutput("reset_busy", 0, {31'd0, busy0}, 32'd0);
    end else begin
      checkOutput("reset_data", 1, {24'd0, data1}, 32'd0);
      checkOutput("reset_valid", 1, {31'd0, valid1}, 32'd0);
      checkOutput("reset_ferr", 1, {31'd0, ferr1}, 32'd0);
      checkOutput("reset_busy", 1, {31'd0, busy1}, 32'd0);
    end
  endtask

  // Monitors: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid0 || ferr0) begin
      if (expQ0.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_strobe dut0: valid=%0b ferr=%0b data=%0h, expected none (cycle %0d)",
                 valid0, ferr0, data0, cyc);
      end else begin
        got0 = expQ0.pop_front();
        compareEvent(0, got0, valid0, ferr0, data0);
      end
    end
  end

  always @(negedge clk) begin
    if (valid1 || ferr1) begin
      if (expQ1.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_strobe dut1: valid=%0b ferr=%0b data=%0h, expected none (cycle %0d)",
                 valid1, ferr1, data1, cyc);
      end else begin
        got1 = expQ1.pop_front();
        compareEvent(1, got1, valid1, ferr1, data1);
      end
    end
  end

  initial begin
    logic [7:0] loopBytes [4];
    logic [7:0] aborted;
    int         k;
    loopBytes[0] = 8'h00;
    loopBytes[1] = 8'hFF;
    loopBytes[2] = 8'h55;
    loopBytes[3] = 8'h80;
    aborted      = 8'hC3;

    rst0 = 1'b1;
    rst1 = 1'b1;
    rxLine[0] = 1'b1;
    rxLine[1] = 1'b1;
    lastGood[0] = 8'h00;
    lastGood[1] = 8'h00;
    waitCycles(3);
    rst0 = 1'b0;
    rst1 = 1'b0;
    checkResetState(0);
    checkResetState(1);
    waitCycles(2);

    $display("[TB] single byte A5 with latency check");
    applyStimulus(0, 8'hA5, 1'b1);
    waitCycles(2 * C0);

    $display("[TB] back-to-back 00 FF 55 80");
    for (int i = 0; i < 4; i++) applyStimulus(0, loopBytes[i], 1'b1);
    waitCycles(C0);

    $display("[TB] start-bit glitch");
    rxLine[0] = 1'b0;
    k = cyc + 1;
    waitCycles(3);
    rxLine[0] = 1'b1;
    checkOutput("glitch_busy_high", 0, {31'd0, busy0}, 32'd1);
    waitCycles(k + 11 - cyc);
    checkOutput("glitch_busy_low", 0, {31'd0, busy0}, 32'd0);
    applyStimulus(0, 8'h3C, 1'b1);
    waitCycles(C0);

    $display("[TB] framing error then held-low break");
    applyStimulus(0, 8'h5A, 1'b0);
    waitCycles(40);
    checkOutput("break_busy", 0, {31'd0, busy0}, 32'd1);
    rxLine[0] = 1'b1;
    waitCycles(5);
    checkOutput("break_released_busy", 0, {31'd0, busy0}, 32'd0);
    checkOutput("ferr_data_kept", 0, {24'd0, data0}, 32'h3C);

    $display("[TB] random bytes with random gaps");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'($urandom), 1'b1);
      waitCycles($urandom_range(0, 2 * C0));
    end
    waitCycles(C0);

    $display("[TB] reset during bit 4 of C3");
    rxLine[0] = 1'b0;
    waitCycles(C0);
    for (int i = 0; i < 4; i++) begin
      rxLine[0] = aborted[i];
      waitCycles(C0);
    end
    rxLine[0] = aborted[4];
    waitCycles(C0 / 2);
    checkOutput("midframe_busy", 0, {31'd0, busy0}, 32'd1);
    rst0 = 1'b1;
    rxLine[0] = 1'b1;
    waitCycles(1);
    rst0 = 1'b0;
    lastGood[0] = 8'h00;
    checkResetState(0);
    waitCycles(2 * C0);
    applyStimulus(0, 8'h11, 1'b1);
    waitCycles(C0);

    $display("[TB] default divisor with E7");
    applyStimulus(1, 8'hE7, 1'b1);
    waitCycles(C1);

    for (int i = 0; i < 4000 && (expQ0.size() != 0 || expQ1.size() != 0); i++) waitCycles(1);
    checkOutput("queue_drained", 0, expQ0.size(), 32'd0);
    checkOutput("queue_drained", 1, expQ1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
